// File: rtl/serial_ripple_sub.sv
// serial_ripple_sub: bit-serial ripple-borrow subtractor that recovers B = sum - A
// from a carry-ripple-add result. It processes one bit per clock through a single
// full-subtractor cell. It also flags results that no legal WIDTH-bit add could produce.
module serial_ripple_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] B,
  output logic             underflow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [WIDTH:0]  m_q, m_d;      // minuend shift register
  logic [WIDTH:0]  s_q, s_d;      // subtrahend shift register
  logic [WIDTH:0]  res_q, res_d;  // difference, filled from the MSB end
  logic            borrow_q, borrow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic            uf_q, uf_d;
  logic            of_q, of_d;
  logic            done_q, done_d;

  logic            last_bit;
  logic            diff_bit;
  logic            borrow_nxt;

  assign last_bit = (cnt_q == CW'(WIDTH));

  // State register and datapath flops; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      m_q      <= '0;
      s_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      s_q      <= s_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
      done_q   <= done_d;
    end
  end

  // Next state: accept start only when idle, and leave RUN after the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == RUN);
  end

  // Full-subtractor cell plus operand/result shifting and result capture.
  always_comb begin
    diff_bit   = m_q[0] ^ s_q[0] ^ borrow_q;
    borrow_nxt = (~m_q[0] & s_q[0]) | (~m_q[0] & borrow_q) | (s_q[0] & borrow_q);

    m_d      = m_q;
    s_d      = s_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    uf_d     = uf_q;
    of_d     = of_q;
    done_d   = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        m_d      = sum;
        s_d      = {1'b0, A};
        borrow_d = 1'b0;
        cnt_d    = '0;
        uf_d     = 1'b0;
        of_d     = 1'b0;
      end
    end else begin
      m_d      = m_q >> 1;
      s_d      = s_q >> 1;
      res_d    = {diff_bit, res_q[WIDTH:1]};
      borrow_d = borrow_nxt;
      cnt_d    = cnt_q + CW'(1);
      if (last_bit) begin
        // res_d now holds the whole WIDTH+1-bit difference, with bit 0 at the LSB.
        b_d    = res_d[WIDTH-1:0];
        uf_d   = borrow_nxt;
        of_d   = diff_bit & ~borrow_nxt;
        done_d = 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign B         = b_q;
  assign underflow = uf_q;
  assign overflow  = of_q;

endmodule

// File: tb/tb_serial_ripple_sub.sv
// Scoreboard bench for serial_ripple_sub. The stimulus pushes hand-computed
// expectations into a queue. The monitor pops and compares one entry on every done.
module tb_serial_ripple_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W:0]   sum;
  logic [W-1:0] A;
  logic         busy, done;
  logic [W-1:0] B;
  logic         underflow, overflow;

  typedef struct {
    logic [W-1:0] b;
    logic         uf;
    logic         of;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   done_at[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_done = 0;

  serial_ripple_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sum(sum), .A(A),
    .busy(busy), .done(done), .B(B), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      done_at.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done with B=%0d expected no done", B);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".B"}, B, e.b);
        chk({e.name, ".underflow"}, underflow, e.uf);
        chk({e.name, ".overflow"}, overflow, e.of);
        chk({e.name, ".busy_at_done"}, busy, 0);
      end
    end
  end

  // Wait (bounded) for an idle or done cycle, then present operands with start high.
  // Start is left high; the caller decides when to drop it.
  task automatic issue(input logic [W:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] eb, input bit euf, input bit eof,
                       input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk({name, ".wait_idle_timeout"}, 1, 0);
    start = 1'b1;
    sum   = s;
    A     = a;
    exp_q.push_back('{eb, euf, eof, name});
    @(posedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({name, ".drain"}, exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int lat, busy_cnt, d0;
    rst = 1'b1; start = 1'b0; sum = '0; A = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.B", B, 0);
    chk("reset.underflow", underflow, 0);
    chk("reset.overflow", overflow, 0);

    // Latency: 377 - 255 = 122, done 9 edges after acceptance.
    issue(9'd377, 8'd255, 8'd122, 0, 0, "lat");
    #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    chk("lat.cycles", lat, 9);
    chk("lat.busy_cycles", busy_cnt, 9);
    drain("lat");

    // Back-to-back with start held high across each done.
    done_at.delete();
    issue(9'd136, 8'd12,  8'd124, 0, 0, "b2b0");
    issue(9'd13,  8'd3,   8'd10,  0, 0, "b2b1");
    issue(9'd230, 8'd200, 8'd30,  0, 0, "b2b2");
    issue(9'd123, 8'd23,  8'd100, 0, 0, "b2b3");
    @(negedge clk);
    start = 1'b0;
    drain("b2b");
    chk("b2b.done_count", done_at.size(), 4);
    if (done_at.size() == 4)
      for (int i = 1; i < 4; i++) chk("b2b.spacing", done_at[i] - done_at[i-1], 10);

    // Underflow and overflow.
    issue(9'd5,   8'd10,  8'd251, 1, 0, "uflow");
    issue(9'd400, 8'd100, 8'd44,  0, 1, "oflow");
    @(negedge clk);
    start = 1'b0;
    drain("flags");

    // Starts while busy are ignored, and operand changes after acceptance have no effect.
    issue(9'd200, 8'd50, 8'd150, 0, 0, "ignore");
    @(negedge clk); start = 1'b0; sum = 9'd10; A = 8'd3;
    @(negedge clk); start = 1'b1; sum = 9'd11; A = 8'd7;
    @(negedge clk); start = 1'b0; sum = 9'd77; A = 8'd99;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); start = 1'b1; sum = 9'd300; A = 8'd1;
    @(negedge clk); start = 1'b0; sum = 9'd0; A = 8'd0;
    drain("ignore");

    // Reset mid-run: the operation is aborted and produces no done.
    @(negedge clk);
    start = 1'b1; sum = 9'd99; A = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    d0 = n_done;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.B", B, 0);
    chk("abort.underflow", underflow, 0);
    chk("abort.overflow", overflow, 0);
    repeat (12) @(negedge clk);
    chk("abort.no_done", n_done - d0, 0);
    issue(9'd99, 8'd9, 8'd90, 0, 0, "after_abort");
    @(negedge clk);
    start = 1'b0;
    drain("after_abort");

    // Edge values.
    issue(9'd0,   8'd0,   8'd0,   0, 0, "edge_zero");
    issue(9'd511, 8'd0,   8'd255, 0, 1, "edge_max");
    issue(9'd0,   8'd255, 8'd1,   1, 0, "edge_under");
    @(negedge clk);
    start = 1'b0;
    drain("edge");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
